alu_arbiter: RTL and testbench

- Shares one combinational ALU instance (module ALU, 32-bit add/sub, NEG/ZERO flags) between two requesters.
- Each requester issues an operation over a valid/ready request channel and gets a registered result and flags back over a valid/ready response channel.
- Sits between issue logic and the ALU.
- Sequences one operation at a time: IDLE -> EXEC -> RESP.

---
 rtl/alu_pkg.sv | 14 +
 rtl/ALU.sv | 21 ++
 rtl/alu_arb_pick.sv | 25 ++
 rtl/alu_arbiter.sv | 143 ++++++++++++++
 tb/tb_alu_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU and its arbiter: opcodes, data width, arbiter states.
package alu_pkg;

    localparam int         ALU_DATA_W = 32;
    localparam logic [3:0] ALU_OP_ADD = 4'b0000;
    localparam logic [3:0] ALU_OP_SUB = 4'b0001;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ALU.sv
// Combinational add/sub ALU with NEG and ZERO flags; any opcode other than SUB adds.
module ALU
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic [3:0]               op,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] result,
    output logic                     neg,
    output logic                     zero
);

    always_comb begin
        result = (op == ALU_OP_SUB) ? (a - b) : (a + b);
        neg    = result[DATA_W-1];
        zero   = (result == '0);
    end

endmodule

// File: rtl/alu_arb_pick.sv
// Grant selection between two requesters: round-robin by default,
// fixed priority to requester 0 when ALU_ARB_FIXED_PRIO_EN is defined.
module alu_arb_pick (
    input  logic valid0,
    input  logic valid1,
`ifndef ALU_ARB_FIXED_PRIO_EN
    input  logic ptr,
`endif
    output logic grant
);

    always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant = ~valid0 & valid1;
`else
        // ptr names the requester preferred under contention
        if (valid0 && valid1) begin
            grant = ptr;
        end else begin
            grant = valid1;
        end
`endif
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one ALU, sequenced IDLE -> EXEC -> RESP.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins) instead of round-robin.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iReqValid0,
    input  logic              iReqValid1,
    output logic              oReqReady0,
    output logic              oReqReady1,
    input  logic [3:0]        iOp0,
    input  logic [3:0]        iOp1,
    input  logic [DATA_W-1:0] iA0,
    input  logic [DATA_W-1:0] iA1,
    input  logic [DATA_W-1:0] iB0,
    input  logic [DATA_W-1:0] iB1,
    output logic              oRespValid0,
    output logic              oRespValid1,
    input  logic              iRespReady0,
    input  logic              iRespReady1,
    output logic [DATA_W-1:0] oResult,
    output logic              oNeg,
    output logic              oZero,
    output logic              oBusy,
    output logic              oGrant
);

    arb_state_e state, state_nxt;

    logic                     pick;
    logic                     accept;
    logic                     resp_ready;
    logic                     grant_r;
    logic [3:0]               op_p0;
    logic signed [DATA_W-1:0] a_p0;
    logic signed [DATA_W-1:0] b_p0;
    logic signed [DATA_W-1:0] alu_res;
    logic                     alu_neg;
    logic                     alu_zero;
    logic signed [DATA_W-1:0] result_p1;
    logic                     neg_p1;
    logic                     zero_p1;

`ifdef ALU_ARB_FIXED_PRIO_EN
    alu_arb_pick u_pick (
        .valid0 (iReqValid0),
        .valid1 (iReqValid1),
        .grant  (pick)
    );
`else
    logic ptr;

    alu_arb_pick u_pick (
        .valid0 (iReqValid0),
        .valid1 (iReqValid1),
        .ptr    (ptr),
        .grant  (pick)
    );

    // The requester just served loses preference for the next contention
    always_ff @(posedge iClk) begin
        if (iRst) begin
            ptr <= 1'b0;
        end else if (state == ARB_RESP && resp_ready) begin
            ptr <= ~grant_r;
        end
    end
`endif

    always_comb begin
        oReqReady0 = (state == ARB_IDLE) && iReqValid0 && !pick;
        oReqReady1 = (state == ARB_IDLE) && iReqValid1 && pick;
        accept     = oReqReady0 || oReqReady1;
        resp_ready = grant_r ? iRespReady1 : iRespReady0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (accept)     state_nxt = ARB_EXEC;
            ARB_EXEC:                 state_nxt = ARB_RESP;
            ARB_RESP: if (resp_ready) state_nxt = ARB_IDLE;
            default:                  state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= ARB_IDLE;
            grant_r <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                grant_r <= pick;
            end
        end
    end

    // Stage p0: operands of the accepted request
    always_ff @(posedge iClk) begin
        if (accept) begin
            op_p0 <= pick ? iOp1 : iOp0;
            a_p0  <= pick ? iA1  : iA0;
            b_p0  <= pick ? iB1  : iB0;
        end
    end

    ALU #(.DATA_W(DATA_W)) u_alu (
        .op     (op_p0),
        .a      (a_p0),
        .b      (b_p0),
        .result (alu_res),
        .neg    (alu_neg),
        .zero   (alu_zero)
    );

    // Stage p1: registered result, held stable through RESP backpressure
    always_ff @(posedge iClk) begin
        if (iRst) begin
            result_p1 <= '0;
            neg_p1    <= 1'b0;
            zero_p1   <= 1'b0;
        end else if (state == ARB_EXEC) begin
            result_p1 <= alu_res;
            neg_p1    <= alu_neg;
            zero_p1   <= alu_zero;
        end
    end

    always_comb begin
        oRespValid0 = (state == ARB_RESP) && !grant_r;
        oRespValid1 = (state == ARB_RESP) && grant_r;
        oResult     = result_p1;
        oNeg        = neg_p1;
        oZero       = zero_p1;
        oBusy       = (state != ARB_IDLE);
        oGrant      = grant_r;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: accepted requests push a modelled result, responses pop and compare.
module tb_alu_arbiter;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              v0, v1, rdy0, rdy1;
    logic [3:0]        op0, op1;
    logic [DATA_W-1:0] a0, a1, b0, b1;
    logic              rv0, rv1, rr0, rr1;
    logic [DATA_W-1:0] result;
    logic              neg, zero, busy, grant;

    typedef struct packed {
        logic              grant;
        logic [DATA_W-1:0] result;
        logic              neg;
        logic              zero;
    } exp_t;

    exp_t exp_q[$];
    logic grant_log[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(DATA_W)) dut (
        .iClk        (clk),
        .iRst        (rst),
        .iReqValid0  (v0),
        .iReqValid1  (v1),
        .oReqReady0  (rdy0),
        .oReqReady1  (rdy1),
        .iOp0        (op0),
        .iOp1        (op1),
        .iA0         (a0),
        .iA1         (a1),
        .iB0         (b0),
        .iB1         (b1),
        .oRespValid0 (rv0),
        .oRespValid1 (rv1),
        .iRespReady0 (rr0),
        .iRespReady1 (rr1),
        .oResult     (result),
        .oNeg        (neg),
        .oZero       (zero),
        .oBusy       (busy),
        .oGrant      (grant)
    );

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, got, want);
    endtask

    function automatic exp_t model(input logic g, input logic [3:0] op,
                                   input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        exp_t e;
        e.grant  = g;
        e.result = (op == 4'b0001) ? (a - b) : (a + b);
        e.neg    = e.result[DATA_W-1];
        e.zero   = (e.result == '0);
        return e;
    endfunction

    task automatic pop_check(input logic g);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq("spurious_resp", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq("resp_owner", 32'(g), 32'(e.grant));
            check_eq("resp_grant", 32'(grant), 32'(e.grant));
            check_eq("resp_result", result, e.result);
            check_eq("resp_neg", 32'(neg), 32'(e.neg));
            check_eq("resp_zero", 32'(zero), 32'(e.zero));
        end
    endtask

    // Scoreboard: push on request handshake, pop on response handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (v0 && rdy0) begin
                exp_q.push_back(model(1'b0, op0, a0, b0));
                grant_log.push_back(1'b0);
            end
            if (v1 && rdy1) begin
                exp_q.push_back(model(1'b1, op1, a1, b1));
                grant_log.push_back(1'b1);
            end
            if (v0 && v1) check_eq("ready_excl", 32'(rdy0 & rdy1), 32'd0);
            if (rv0 && rr0) pop_check(1'b0);
            if (rv1 && rr1) pop_check(1'b1);
        end
    end

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_result"}, result, '0);
        check_eq({tag, "_flags"}, 32'({neg, zero}), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_grant"}, 32'(grant), 32'd0);
        check_eq({tag, "_respvalid"}, 32'({rv0, rv1}), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic issue(input int r, input logic [3:0] op,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic ok;
        ok = 1'b0;
        @(posedge clk); #1;
        if (r == 0) begin v0 = 1'b1; op0 = op; a0 = a; b0 = b; end
        else        begin v1 = 1'b1; op1 = op; a1 = a; b1 = b; end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((r == 0) ? rdy0 : rdy1) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("req_accept", 32'(ok), 32'd1);
        @(posedge clk); #1;
        if (r == 0) v0 = 1'b0;
        else        v1 = 1'b0;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("idle_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_rv0();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rv0) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("rv0_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_g;
        rst = 1'b1;
        v0 = 1'b0; v1 = 1'b0; op0 = '0; op1 = '0;
        a0 = '0; a1 = '0; b0 = '0; b1 = '0;
        rr0 = 1'b0; rr1 = 1'b0;

        do_reset();
        @(negedge clk);
        check_zero_outputs("reset");

        // Single add: ready in same cycle, response two edges after acceptance
        rr0 = 1'b1;
        @(posedge clk); #1;
        v0 = 1'b1; op0 = 4'b0000; a0 = 32'd5; b0 = 32'd7;
        @(negedge clk);
        check_eq("t1_ready0", 32'(rdy0), 32'd1);
        @(posedge clk); #1;
        v0 = 1'b0;
        @(negedge clk);
        check_eq("t1_exec_rv0", 32'(rv0), 32'd0);
        @(negedge clk);
        check_eq("t1_resp_rv0", 32'(rv0), 32'd1);
        check_eq("t1_result", result, 32'd12);
        wait_idle();

        rr1 = 1'b1;
        issue(1, 4'b0001, 32'd0, 32'd1);
        wait_idle();
        issue(1, 4'b0000, 32'hFFFF_FFFF, 32'd1);
        wait_idle();
        issue(0, 4'b0111, 32'd3, 32'd4);
        wait_idle();

        // Continuous contention right after reset
        do_reset();
        grant_log.delete();
        rr0 = 1'b1; rr1 = 1'b1;
        v0 = 1'b1; op0 = 4'b0000; a0 = 32'd10; b0 = 32'd1;
        v1 = 1'b1; op1 = 4'b0001; a1 = 32'd10; b1 = 32'd1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (grant_log.size() >= 4) break;
        end
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b0;
        check_eq("contend_count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_g = 1'b0;
`else
            exp_g = i[0];
`endif
            if (i < grant_log.size()) check_eq("contend_grant", 32'(grant_log[i]), 32'(exp_g));
        end
        wait_idle();

        // Backpressure on requester 0 while requester 1 waits
        rr0 = 1'b0; rr1 = 1'b1;
        issue(0, 4'b0000, 32'd100, 32'd23);
        v1 = 1'b1; op1 = 4'b0001; a1 = 32'd50; b1 = 32'd8;
        wait_rv0();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("bp_rv0", 32'(rv0), 32'd1);
            check_eq("bp_result", result, 32'd123);
            check_eq("bp_ready1", 32'(rdy1), 32'd0);
        end
        @(posedge clk); #1;
        rr0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("bp_ready1_after", 32'(rdy1), 32'd1);
        @(posedge clk); #1;
        v1 = 1'b0;
        wait_idle();

        // Reset during EXEC
        @(posedge clk); #1;
        v0 = 1'b1; op0 = 4'b0000; a0 = 32'd1; b0 = 32'd2;
        @(negedge clk);
        check_eq("rexec_accept", 32'(rdy0), 32'd1);
        @(posedge clk); #1;
        v0 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_eq("rexec_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_zero_outputs("rexec");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rexec_no_resp", 32'({rv0, rv1}), 32'd0);
        end

        // Reset during RESP
        rr0 = 1'b0;
        issue(0, 4'b0001, 32'd9, 32'd4);
        wait_rv0();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_zero_outputs("rresp");
        rr0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rresp_no_resp", 32'({rv0, rv1}), 32'd0);
        end

        issue(1, 4'b0000, 32'd20, 32'd22);
        wait_idle();
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
